// File: rtl/at25010_responder.sv
// at25010_responder
// AT25010-compatible SPI EEPROM responder (128 x 8, SPI mode 0). Every part of it runs in the
// system clock domain. The SPI pins are synchronized and edge-detected. Supported opcodes are
// WREN, WRDI, RDSR, WRSR, READ and WRITE, with 8-byte page writes, block protection and a
// timed write cycle.
//
// Ports:
//   clk       system clock (rising edge)
//   rst       asynchronous active-high reset
//   spi_cs_n  chip select, active low (asynchronous to clk)
//   spi_sclk  SPI clock, idle low (asynchronous to clk)
//   spi_mosi  serial data in, MSB first
//   spi_miso  serial data out, MSB first; 1 when not driving data
//   busy      write cycle in progress (status bit 0)
//   status    live status register {4'b0, BP1, BP0, WEL, WIP}
module at25010_responder #(
   parameter int unsigned WRITE_CYCLES = 1000,
   parameter logic [7:0]  MEM_INIT     = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_cs_n,
   input  logic       spi_sclk,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       busy,
   output logic [7:0] status
);

   localparam logic [7:0] OP_WRSR  = 8'h01;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRDI  = 8'h04;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_WREN  = 8'h06;

   localparam int unsigned TW = $clog2(WRITE_CYCLES);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(WRITE_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StOpcode,
      StAddr,
      StDataIn,
      StDataOut,
      StIgnore
   } state_e;

   state_e state_q, state_d;

   // Power-up content only; the array is never reset.
   logic [7:0] mem [128] = '{default: MEM_INIT};

   logic [1:0] cs_sync, sclk_sync, mosi_sync;
   logic       cs_prev, sclk_prev;
   logic       cs_n_s, mosi_s, sclk_rise, sclk_fall, cs_rise;

   logic [2:0]    bit_cnt_q;
   logic [6:0]    shift_in_q;
   logic [7:0]    shift_out_q;
   logic [7:0]    opcode_q;
   logic [6:0]    addr_q;
   logic          miso_q;
   logic          wel_q;
   logic [1:0]    bp_q;
   logic [1:0]    wrsr_bp_q;
   logic          wip_q;
   logic [TW-1:0] timer_q;
   logic [1:0]    data_cnt_q;
   logic [3:0]    page_base_q;
   logic [2:0]    page_off_q;
   logic [7:0]    page_valid_q;
   logic [7:0]    page_buf_q [8];
   logic          copy_active_q;
   logic [2:0]    copy_idx_q;

   logic [7:0] rx_byte;
   logic [7:0] status_w;
   logic       byte_done;
   logic       page_prot;
   logic       write_commit;
   logic       wrsr_commit;

   // Input synchronizers and edge detectors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync   <= 2'b11;
         sclk_sync <= 2'b00;
         mosi_sync <= 2'b00;
         cs_prev   <= 1'b1;
         sclk_prev <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[0], spi_cs_n};
         sclk_sync <= {sclk_sync[0], spi_sclk};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         cs_prev   <= cs_sync[1];
         sclk_prev <= sclk_sync[1];
      end
   end

   assign cs_n_s    = cs_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign sclk_rise = sclk_sync[1] & ~sclk_prev;
   assign sclk_fall = ~sclk_sync[1] & sclk_prev;
   assign cs_rise   = cs_sync[1] & ~cs_prev;

   assign rx_byte   = {shift_in_q, mosi_s};
   assign status_w  = {4'b0000, bp_q, wel_q, wip_q};
   assign byte_done = sclk_rise && !cs_n_s && (state_q != StIdle) && (bit_cnt_q == 3'd7);

   // Protected regions are aligned to 8-byte pages, so the page base alone decides.
   always_comb begin
      page_prot = 1'b0;
      case (bp_q)
         2'b01:   page_prot = (page_base_q[3:2] == 2'b11);
         2'b10:   page_prot = page_base_q[3];
         2'b11:   page_prot = 1'b1;
         default: page_prot = 1'b0;
      endcase
   end

   // Commits are judged with pre-edge state: the frame state and bit counter are only
   // cleared on the same edge that sees the CS rise.
   assign write_commit = cs_rise && !wip_q && (state_q == StDataIn) && (opcode_q == OP_WRITE) &&
                         (bit_cnt_q == 3'd0) && (data_cnt_q != 2'd0) && wel_q && !page_prot;
   assign wrsr_commit  = cs_rise && (state_q == StDataIn) && (opcode_q == OP_WRSR) &&
                         (bit_cnt_q == 3'd0) && (data_cnt_q == 2'd1) && wel_q;

   // Frame FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (cs_n_s) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: state_d = StOpcode;
            StOpcode: begin
               if (byte_done) begin
                  if (wip_q) begin
                     state_d = (rx_byte == OP_RDSR) ? StDataOut : StIgnore;
                  end else begin
                     case (rx_byte)
                        OP_RDSR:           state_d = StDataOut;
                        OP_WRSR:           state_d = StDataIn;
                        OP_READ, OP_WRITE: state_d = StAddr;
                        default:           state_d = StIgnore;
                     endcase
                  end
               end
            end
            StAddr: begin
               if (byte_done) begin
                  state_d = (opcode_q == OP_READ) ? StDataOut : StDataIn;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Datapath: shifting, opcode effects, page buffer, status and write cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q     <= 3'd0;
         shift_in_q    <= 7'd0;
         shift_out_q   <= 8'd0;
         opcode_q      <= 8'd0;
         addr_q        <= 7'd0;
         miso_q        <= 1'b1;
         wel_q         <= 1'b0;
         bp_q          <= 2'b00;
         wrsr_bp_q     <= 2'b00;
         wip_q         <= 1'b0;
         timer_q       <= '0;
         data_cnt_q    <= 2'd0;
         page_base_q   <= 4'd0;
         page_off_q    <= 3'd0;
         page_valid_q  <= 8'd0;
         copy_active_q <= 1'b0;
         copy_idx_q    <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            page_buf_q[i] <= 8'd0;
         end
      end else begin
         if (cs_n_s) begin
            bit_cnt_q  <= 3'd0;
            data_cnt_q <= 2'd0;
         end else if (sclk_rise && (state_q != StIdle)) begin
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            shift_in_q <= rx_byte[6:0];
         end

         if (byte_done) begin
            case (state_q)
               StOpcode: begin
                  opcode_q <= rx_byte;
                  if (!wip_q && (rx_byte == OP_WREN)) wel_q <= 1'b1;
                  if (!wip_q && (rx_byte == OP_WRDI)) wel_q <= 1'b0;
                  if (rx_byte == OP_RDSR) shift_out_q <= status_w;
               end
               StAddr: begin
                  if (opcode_q == OP_READ) begin
                     shift_out_q <= mem[rx_byte[6:0]];
                     addr_q      <= rx_byte[6:0] + 7'd1;
                  end else begin
                     page_base_q  <= rx_byte[6:3];
                     page_off_q   <= rx_byte[2:0];
                     page_valid_q <= 8'd0;
                  end
               end
               StDataIn: begin
                  if (opcode_q == OP_WRITE) begin
                     page_buf_q[page_off_q]   <= rx_byte;
                     page_valid_q[page_off_q] <= 1'b1;
                     page_off_q               <= page_off_q + 3'd1;
                  end
                  wrsr_bp_q <= rx_byte[3:2];
                  if (data_cnt_q != 2'd2) data_cnt_q <= data_cnt_q + 2'd1;
               end
               StDataOut: begin
                  if (opcode_q == OP_READ) begin
                     shift_out_q <= mem[addr_q];
                     addr_q      <= addr_q + 7'd1;
                  end else begin
                     shift_out_q <= status_w;
                  end
               end
               default: ;
            endcase
         end

         if (cs_n_s || (state_q != StDataOut)) begin
            miso_q <= 1'b1;
         end else if (sclk_fall) begin
            miso_q      <= shift_out_q[7];
            shift_out_q <= {shift_out_q[6:0], 1'b0};
         end

         if (wrsr_commit) begin
            bp_q  <= wrsr_bp_q;
            wel_q <= 1'b0;
         end

         // Copy walks all eight slots, one per clk, writing only the valid ones.
         if (copy_active_q) begin
            copy_idx_q <= copy_idx_q + 3'd1;
            if (copy_idx_q == 3'd7) copy_active_q <= 1'b0;
         end

         if (write_commit) begin
            wip_q         <= 1'b1;
            timer_q       <= TIMER_LOAD;
            copy_active_q <= 1'b1;
            copy_idx_q    <= 3'd0;
         end else if (wip_q) begin
            if (timer_q == '0) begin
               wip_q <= 1'b0;
               wel_q <= 1'b0;
            end else begin
               timer_q <= timer_q - TW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (copy_active_q && page_valid_q[copy_idx_q]) begin
         mem[{page_base_q, copy_idx_q}] <= page_buf_q[copy_idx_q];
      end
   end

   assign spi_miso = miso_q;
   assign busy     = wip_q;
   assign status   = status_w;

endmodule
